// File: rtl/iter_muldiv_unit_if.sv
// rtl/iter_muldiv_unit_if.sv - issue/result bundle between control, register file and muldiv unit
interface iter_muldiv_unit_if #(
    parameter int XLEN = 32
);
    logic            start;
    logic [1:0]      op;
    logic            signed_op;
    logic [XLEN-1:0] operand_a;
    logic [XLEN-1:0] operand_b;
    logic [4:0]      dest_reg;
    logic            busy;
    logic            done;
    logic [XLEN-1:0] result;
    logic            wb_en;
    logic [4:0]      wb_reg;

    modport master (
        output start, op, signed_op, operand_a, operand_b, dest_reg,
        input  busy, done, result, wb_en, wb_reg
    );

    modport slave (
        input  start, op, signed_op, operand_a, operand_b, dest_reg,
        output busy, done, result, wb_en, wb_reg
    );
endinterface

// File: rtl/iter_muldiv_unit.sv
// rtl/iter_muldiv_unit.sv - iterative shift-add multiplier / restoring divider with register write-back
module iter_muldiv_unit #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 6
) (
    input  logic               clk,
    input  logic               rst_n,
    iter_muldiv_unit_if.slave  bus
);
    localparam logic [1:0] OP_MUL  = 2'b00;
    localparam logic [1:0] OP_MULH = 2'b01;
    localparam logic [1:0] OP_DIV  = 2'b10;
    localparam logic [1:0] OP_REM  = 2'b11;
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(XLEN - 1);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic [1:0]        op_q;
    logic              neg_q;
    logic [XLEN-1:0]   a_q;
    logic [XLEN-1:0]   b_q;
    logic [XLEN-1:0]   rem_q;
    logic [2*XLEN-1:0] prod_q;
    logic [XLEN-1:0]   result_q;
    logic [4:0]        wb_reg_q;
    logic              busy_q;
    logic              done_q;

    logic              sign_a;
    logic              sign_b;
    logic [XLEN-1:0]   abs_a;
    logic [XLEN-1:0]   abs_b;
    logic              div_zero;
    logic              start_neg;

    logic [XLEN:0]     mul_sum;
    logic [2*XLEN-1:0] prod_nxt;
    logic [XLEN:0]     div_shift;
    logic [XLEN:0]     div_trial;
    logic              div_ok;
    logic [XLEN-1:0]   rem_nxt;
    logic [XLEN-1:0]   quo_nxt;

    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   quo_fix;
    logic [XLEN-1:0]   rem_fix;
    logic [XLEN-1:0]   final_res;

    // Operand conditioning at issue: magnitudes plus the sign the result must carry.
    always_comb begin
        sign_a   = bus.signed_op & bus.operand_a[XLEN-1];
        sign_b   = bus.signed_op & bus.operand_b[XLEN-1];
        abs_a    = sign_a ? (~bus.operand_a + 1'b1) : bus.operand_a;
        abs_b    = sign_b ? (~bus.operand_b + 1'b1) : bus.operand_b;
        div_zero = (bus.operand_b == '0);
        start_neg = sign_a ^ sign_b;
        case (bus.op)
            OP_REM:  start_neg = sign_a;
            // Quotient of x/0 must stay all ones regardless of operand signs.
            OP_DIV:  start_neg = div_zero ? 1'b0 : (sign_a ^ sign_b);
            default: start_neg = sign_a ^ sign_b;
        endcase
    end

    // One iteration of each datapath; the last one feeds sign correction in the same edge.
    always_comb begin
        mul_sum   = {1'b0, prod_q[2*XLEN-1:XLEN]} + (prod_q[0] ? {1'b0, a_q} : {(XLEN+1){1'b0}});
        prod_nxt  = {mul_sum, prod_q[XLEN-1:1]};

        div_shift = {rem_q, a_q[XLEN-1]};
        div_trial = div_shift - {1'b0, b_q};
        div_ok    = ~div_trial[XLEN];
        rem_nxt   = div_ok ? div_trial[XLEN-1:0] : div_shift[XLEN-1:0];
        quo_nxt   = {a_q[XLEN-2:0], div_ok};

        prod_fix  = neg_q ? (~prod_nxt + 1'b1) : prod_nxt;
        quo_fix   = neg_q ? (~quo_nxt + 1'b1) : quo_nxt;
        rem_fix   = neg_q ? (~rem_nxt + 1'b1) : rem_nxt;

        case (op_q)
            OP_MUL:  final_res = prod_fix[XLEN-1:0];
            OP_MULH: final_res = prod_fix[2*XLEN-1:XLEN];
            OP_DIV:  final_res = quo_fix;
            default: final_res = rem_fix;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= '0;
            op_q     <= '0;
            neg_q    <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            rem_q    <= '0;
            prod_q   <= '0;
            result_q <= '0;
            wb_reg_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        op_q     <= bus.op;
                        neg_q    <= start_neg;
                        wb_reg_q <= bus.dest_reg;
                        a_q      <= abs_a;
                        b_q      <= abs_b;
                        rem_q    <= '0;
                        prod_q   <= {{XLEN{1'b0}}, abs_b};
                        cnt      <= '0;
                        busy_q   <= 1'b1;
                        state    <= CALC;
                    end
                end
                CALC: begin
                    cnt <= cnt + 1'b1;
                    if (!op_q[1]) begin
                        prod_q <= prod_nxt;
                    end else begin
                        a_q   <= quo_nxt;
                        rem_q <= rem_nxt;
                    end
                    if (cnt == LAST_ITER) begin
                        result_q <= final_res;
                        done_q   <= 1'b1;
                        state    <= DONE;
                    end
                end
                DONE: begin
                    done_q <= 1'b0;
                    busy_q <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    done_q <= 1'b0;
                    busy_q <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.wb_en  = done_q;
    assign bus.result = result_q;
    assign bus.wb_reg = wb_reg_q;
endmodule

// File: tb/tb_iter_muldiv_unit.sv
// tb/tb_iter_muldiv_unit.sv - randomized and directed checks of iter_muldiv_unit against an arithmetic model
module tb_iter_muldiv_unit;
    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    iter_muldiv_unit_if #(.XLEN(32)) bus ();

    iter_muldiv_unit #(.XLEN(32), .CNT_W(6)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] model(input logic [1:0] op, input logic s,
                                          input logic [31:0] a, input logic [31:0] b);
        longint      pa;
        longint      pb;
        logic [63:0] p;
        int          sa;
        int          sb;
        sa = a;
        sb = b;
        if (s) begin
            pa = sa;
            pb = sb;
        end else begin
            pa = {32'b0, a};
            pb = {32'b0, b};
        end
        p = pa * pb;
        case (op)
            2'd0: return p[31:0];
            2'd1: return p[63:32];
            2'd2: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                if (s) return sa / sb;
                return a / b;
            end
            default: begin
                if (b == 0) return a;
                if (s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
                if (s) return sa % sb;
                return a % b;
            end
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic run_op(input string tag, input logic [1:0] op, input logic s,
                          input logic [31:0] a, input logic [31:0] b, input logic [4:0] dst);
        int          n;
        logic [31:0] exp;
        exp = model(op, s, a, b);
        @(negedge clk);
        bus.op        = op;
        bus.signed_op = s;
        bus.operand_a = a;
        bus.operand_b = b;
        bus.dest_reg  = dst;
        bus.start     = 1'b1;
        @(posedge clk);
        #1;
        bus.start     = 1'b0;
        bus.operand_a = $urandom;
        bus.operand_b = $urandom;
        bus.dest_reg  = 5'($urandom);
        bus.signed_op = ~s;
        check({tag, ".busy"}, 32'(bus.busy), 32'd1);
        n = 0;
        while (!bus.done && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        check({tag, ".lat"}, 32'(n), 32'd32);
        check({tag, ".res"}, bus.result, exp);
        check({tag, ".wben"}, 32'(bus.wb_en), 32'd1);
        check({tag, ".wbreg"}, 32'(bus.wb_reg), 32'(dst));
        @(posedge clk);
        #1;
        check({tag, ".pulse"}, {30'b0, bus.done, bus.wb_en}, 32'd0);
        check({tag, ".idle"}, 32'(bus.busy), 32'd0);
        check({tag, ".hold"}, bus.result, exp);
    endtask

    initial begin
        int          dcount;
        int          dat;
        int          busy_err;
        logic [31:0] res;
        logic [31:0] corner [5];
        logic [31:0] ra;
        logic [31:0] rb;

        total = 0;
        bad   = 0;
        corner[0] = 32'h0;
        corner[1] = 32'h1;
        corner[2] = 32'hFFFF_FFFF;
        corner[3] = 32'h8000_0000;
        corner[4] = 32'h7FFF_FFFF;

        rst_n         = 1'b0;
        bus.start     = 1'b0;
        bus.op        = 2'd0;
        bus.signed_op = 1'b0;
        bus.operand_a = '0;
        bus.operand_b = '0;
        bus.dest_reg  = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset.out", {29'b0, bus.busy, bus.done, bus.wb_en}, 32'd0);
        check("reset.res", bus.result, 32'd0);
        check("reset.wbreg", 32'(bus.wb_reg), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        run_op("mul7x6",    2'd0, 1'b0, 32'd7, 32'd6, 5'd3);
        run_op("mulh_uff",  2'd1, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd4);
        run_op("mul_uff",   2'd0, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd5);
        run_op("mulh_sff",  2'd1, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd6);
        run_op("sdiv_m7",   2'd2, 1'b1, 32'hFFFF_FFF9, 32'd2, 5'd7);
        run_op("srem_m7",   2'd3, 1'b1, 32'hFFFF_FFF9, 32'd2, 5'd8);
        run_op("udiv100",   2'd2, 1'b0, 32'd100, 32'd7, 5'd9);
        run_op("urem100",   2'd3, 1'b0, 32'd100, 32'd7, 5'd10);
        run_op("div0",      2'd2, 1'b0, 32'd100, 32'd0, 5'd11);
        run_op("rem0",      2'd3, 1'b0, 32'd100, 32'd0, 5'd12);
        run_op("sdiv0neg",  2'd2, 1'b1, 32'hFFFF_FF00, 32'd0, 5'd13);
        run_op("srem0neg",  2'd3, 1'b1, 32'hFFFF_FF00, 32'd0, 5'd14);
        run_op("sdivovf",   2'd2, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 5'd15);
        run_op("sremovf",   2'd3, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 5'd16);

        for (int i = 0; i < 24; i++) begin
            ra = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 4)] : $urandom;
            rb = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 4)] : $urandom;
            if ($urandom_range(0, 2) == 0) rb = rb >> $urandom_range(1, 31);
            run_op($sformatf("rnd%0d", i), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                   ra, rb, 5'($urandom));
        end

        // A second start in the middle of a multiply must be ignored.
        @(negedge clk);
        bus.op        = 2'd0;
        bus.signed_op = 1'b0;
        bus.operand_a = 32'd3;
        bus.operand_b = 32'd5;
        bus.dest_reg  = 5'd21;
        bus.start     = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        dcount   = 0;
        dat      = 0;
        busy_err = 0;
        res      = '0;
        for (int c = 1; c <= 40; c++) begin
            if (c == 10) begin
                bus.start     = 1'b1;
                bus.op        = 2'd2;
                bus.operand_a = 32'd100;
                bus.operand_b = 32'd7;
                bus.dest_reg  = 5'd9;
            end
            if (c == 11) bus.start = 1'b0;
            @(posedge clk);
            #1;
            if (bus.done) begin
                dcount++;
                dat = c;
                res = bus.result;
            end
            if (c <= 32 && !bus.busy) busy_err++;
            if (c == 33) check("hs.busy_exit", 32'(bus.busy), 32'd0);
        end
        check("hs.dcount", 32'(dcount), 32'd1);
        check("hs.dat", 32'(dat), 32'd32);
        check("hs.res", res, 32'd15);
        check("hs.busy", 32'(busy_err), 32'd0);
        check("hs.wbreg", 32'(bus.wb_reg), 32'd21);

        // Asynchronous reset halfway through an operation.
        @(negedge clk);
        bus.op        = 2'd0;
        bus.operand_a = 32'd7;
        bus.operand_b = 32'd7;
        bus.dest_reg  = 5'd30;
        bus.start     = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (16) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst.out", {29'b0, bus.busy, bus.done, bus.wb_en}, 32'd0);
        check("rst.res", bus.result, 32'd0);
        check("rst.wbreg", 32'(bus.wb_reg), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        dcount = 0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk);
            #1;
            if (bus.done || bus.wb_en || bus.busy) dcount++;
        end
        check("rst.quiet", 32'(dcount), 32'd0);
        run_op("mul9x9", 2'd0, 1'b0, 32'd9, 32'd9, 5'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
